// File: rtl/mirfak_wb_sram_slave_pkg.sv
// Shared types and constants for the Mirfak Wishbone SRAM slave.
//   wbs_st_e  : responder FSM states (IDLE/WAIT/RESP)
//   word_t    : bus word split into byte lanes
//   wbs_req_t : request fields captured when a request is accepted
//   in_window : address-window decode helper
package mirfak_wb_sram_slave_pkg;
  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DATA_W    = NUM_LANES * LANE_W;
  localparam int WAIT_MAX  = 15;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wbs_st_e;

  typedef logic [NUM_LANES-1:0][LANE_W-1:0] word_t;

  typedef struct packed {
    word_t                dat;
    logic [NUM_LANES-1:0] sel;
    logic                 we;
    logic                 hit;
  } wbs_req_t;

  // 33-bit compare so a window ending at 4 GiB does not wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int          aw);
    logic [32:0] lo, hi, a;
    lo = {1'b0, base};
    hi = lo + (33'd4 << aw);
    a  = {1'b0, addr};
    return (a >= lo) && (a < hi);
  endfunction
endpackage

// File: rtl/mirfak_wb_sram_slave_if.sv
// Wishbone classic slave bundle.
//   master : drives addr/dat_i/sel/cyc/stb/we, receives dat_o/ack/err
//   slave  : the opposite view
interface mirfak_wb_sram_slave_if;
  import mirfak_wb_sram_slave_pkg::*;
  logic [31:0]          wbs_addr_i;
  logic [DATA_W-1:0]    wbs_dat_i;
  logic [NUM_LANES-1:0] wbs_sel_i;
  logic                 wbs_cyc_i;
  logic                 wbs_stb_i;
  logic                 wbs_we_i;
  logic [DATA_W-1:0]    wbs_dat_o;
  logic                 wbs_ack_o;
  logic                 wbs_err_o;

  modport master (output wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_cyc_i, wbs_stb_i, wbs_we_i,
                  input  wbs_dat_o, wbs_ack_o, wbs_err_o);
  modport slave  (input  wbs_addr_i, wbs_dat_i, wbs_sel_i, wbs_cyc_i, wbs_stb_i, wbs_we_i,
                  output wbs_dat_o, wbs_ack_o, wbs_err_o);
endinterface

// File: rtl/mirfak_ram_1rw_be.sv
// Single-port word RAM with per-byte write enables and a registered read.
//   clk_i : clock
//   we/be : write strobe and byte-lane enables
//   re    : read strobe; rdata updates only when re=1 and holds otherwise
//   addr  : word index
//   wdata : write word, rdata : read word (one cycle after re)
module mirfak_ram_1rw_be
  import mirfak_wb_sram_slave_pkg::*;
#(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic                  re,
  input  logic [NUM_LANES-1:0]  be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  word_t                 wdata,
  output word_t                 rdata
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  word_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (be[l]) mem[addr][l] <= wdata[l];
      end
    end
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mirfak_wb_sram_slave.sv
// Wishbone classic-cycle SRAM responder.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   wbs    : slave view of the Wishbone bundle (addr/dat/sel/cyc/stb/we in,
//            dat_o/ack/err out)
// A request accepted in IDLE waits WAIT_STATES cycles, then the memory access
// and the registered ack (hit) or err (miss) happen on the edge entering RESP.
module mirfak_wb_sram_slave
  import mirfak_wb_sram_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  mirfak_wb_sram_slave_if.slave wbs
);
  localparam int WS_EFF = (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;
  localparam logic [CNT_W-1:0] CNT_LOAD = (WS_EFF == 0) ? '0 : CNT_W'(WS_EFF - 1);

  wbs_st_e               st_q, st_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  wbs_req_t              req_q, req_bus, acc;
  logic [ADDR_WIDTH-1:0] idx_q, idx_bus, acc_idx;
  logic                  req_vld, go_resp, use_bus;
  logic                  ack_q, err_q, dat_vld_q;
  logic                  ram_we, ram_re;
  word_t                 ram_rdata;

  assign req_vld = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  assign idx_bus = wbs.wbs_addr_i[ADDR_WIDTH+1:2];

  always_comb begin
    req_bus.dat = wbs.wbs_dat_i;
    req_bus.sel = wbs.wbs_sel_i;
    req_bus.we  = wbs.wbs_we_i;
    req_bus.hit = in_window(wbs.wbs_addr_i, BASE_ADDR, ADDR_WIDTH);
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    use_bus = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (req_vld) begin
          if (WS_EFF == 0) begin
            // Zero wait states: access straight from the bus this edge.
            st_d    = ST_RESP;
            go_resp = 1'b1;
            use_bus = 1'b1;
          end else begin
            st_d  = ST_WAIT;
            cnt_d = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!wbs.wbs_cyc_i) begin
          st_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          st_d    = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  assign acc     = use_bus ? req_bus : req_q;
  assign acc_idx = use_bus ? idx_bus : idx_q;
  // The array has no reset, so hold off any access while reset is asserted.
  assign ram_we  = rst_ni & go_resp & acc.hit &  acc.we;
  assign ram_re  = rst_ni & go_resp & acc.hit & ~acc.we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      idx_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_vld_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      if (st_q == ST_IDLE && req_vld) begin
        req_q <= req_bus;
        idx_q <= idx_bus;
      end
      ack_q <= go_resp &  acc.hit;
      err_q <= go_resp & ~acc.hit;
      if (ram_re) dat_vld_q <= 1'b1;
    end
  end

  mirfak_ram_1rw_be #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk_i (clk_i),
    .we    (ram_we),
    .re    (ram_re),
    .be    (acc.sel),
    .addr  (acc_idx),
    .wdata (acc.dat),
    .rdata (ram_rdata)
  );

  // RAM read register is not reset; dat_vld_q gives dat_o its zero reset value
  // and the RAM only reads on read hits, so the last read word is held.
  assign wbs.wbs_dat_o = dat_vld_q ? ram_rdata : '0;
  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_err_o = err_q;
endmodule

// File: tb/tb_mirfak_wb_sram_slave.sv
// Bench: two responders (A: zero wait states, base 0; B: three wait states,
// nonzero base) on shared request lines with separate cyc. A word-array model
// predicts hit/miss, latency and data from the address window and byte lanes.
module tb_mirfak_wb_sram_slave;
  localparam int          AW_A   = 8;
  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam int          WS_A   = 0;
  localparam int          AW_B   = 6;
  localparam logic [31:0] BASE_B = 32'h0000_1000;
  localparam int          WS_B   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] t_addr, t_dat;
  logic [3:0]  t_sel;
  logic        t_we, t_stb, cyc_a, cyc_b;

  always #5 clk = ~clk;

  mirfak_wb_sram_slave_if if_a ();
  mirfak_wb_sram_slave_if if_b ();

  assign if_a.wbs_addr_i = t_addr;
  assign if_a.wbs_dat_i  = t_dat;
  assign if_a.wbs_sel_i  = t_sel;
  assign if_a.wbs_we_i   = t_we;
  assign if_a.wbs_stb_i  = t_stb;
  assign if_a.wbs_cyc_i  = cyc_a;
  assign if_b.wbs_addr_i = t_addr;
  assign if_b.wbs_dat_i  = t_dat;
  assign if_b.wbs_sel_i  = t_sel;
  assign if_b.wbs_we_i   = t_we;
  assign if_b.wbs_stb_i  = t_stb;
  assign if_b.wbs_cyc_i  = cyc_b;

  mirfak_wb_sram_slave #(.ADDR_WIDTH(AW_A), .BASE_ADDR(BASE_A), .WAIT_STATES(WS_A), .INIT_FILE(""))
    dut_a (.clk_i(clk), .rst_ni(rst_n), .wbs(if_a));
  mirfak_wb_sram_slave #(.ADDR_WIDTH(AW_B), .BASE_ADDR(BASE_B), .WAIT_STATES(WS_B), .INIT_FILE(""))
    dut_b (.clk_i(clk), .rst_ni(rst_n), .wbs(if_b));

  logic [31:0] mem_a [2**AW_A];
  logic [31:0] mem_b [2**AW_B];
  logic [31:0] last_a, last_b;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_base(input bit b);
    return b ? BASE_B : BASE_A;
  endfunction
  function automatic int m_words(input bit b);
    return b ? 2**AW_B : 2**AW_A;
  endfunction
  function automatic bit m_hit(input bit b, input logic [31:0] a);
    return (a >= m_base(b)) && ((a - m_base(b)) < 32'(4 * m_words(b)));
  endfunction
  function automatic int m_idx(input bit b, input logic [31:0] a);
    return int'((a - m_base(b)) >> 2);
  endfunction

  function automatic logic o_ack(input bit b);
    return b ? if_b.wbs_ack_o : if_a.wbs_ack_o;
  endfunction
  function automatic logic o_err(input bit b);
    return b ? if_b.wbs_err_o : if_a.wbs_err_o;
  endfunction
  function automatic logic [31:0] o_dat(input bit b);
    return b ? if_b.wbs_dat_o : if_a.wbs_dat_o;
  endfunction

  // One transaction, called at #1 after a rising edge with the slave idle.
  task automatic txn(input bit b, input bit we, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s, input bit keep);
    int lat;
    bit got, hit;
    logic [31:0] exp_d, old;
    hit = m_hit(b, a);
    t_addr = a; t_dat = d; t_sel = s; t_we = we; t_stb = 1'b1;
    if (b) cyc_b = 1'b1; else cyc_a = 1'b1;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      got = o_ack(b) | o_err(b);
    end
    chk("latency", lat, (b ? WS_B : WS_A) + 1);
    chk("ack", {31'b0, o_ack(b)}, {31'b0, hit});
    chk("err", {31'b0, o_err(b)}, {31'b0, !hit});
    exp_d = b ? last_b : last_a;
    if (hit) begin
      old = b ? mem_b[m_idx(b, a)] : mem_a[m_idx(b, a)];
      if (!we) exp_d = old;
      else for (int n = 0; n < 4; n++) if (s[n]) old[8*n +: 8] = d[8*n +: 8];
      if (b) mem_b[m_idx(b, a)] = old; else mem_a[m_idx(b, a)] = old;
    end
    chk(we ? "dat_hold" : "rdata", o_dat(b), exp_d);
    if (b) last_b = exp_d; else last_a = exp_d;
    if (!keep) begin t_stb = 1'b0; cyc_a = 1'b0; cyc_b = 1'b0; end
    @(posedge clk); #1;
    chk("pulse", {30'b0, o_ack(b), o_err(b)}, 32'd0);
  endtask

  function automatic logic [31:0] rnd_addr(input bit b);
    int r;
    r = $urandom_range(0, 99);
    if (r < 85) return m_base(b) + 32'(4 * $urandom_range(0, m_words(b) - 1)) + 32'($urandom_range(0, 3));
    if (r < 92) return m_base(b) + 32'(4 * m_words(b)) + 32'(4 * $urandom_range(0, 3));
    if (r < 96 && m_base(b) != 0) return m_base(b) - 32'(4 * $urandom_range(1, 3));
    return $urandom;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d, sticky;
    rst_n = 1'b0;
    t_addr = '0; t_dat = '0; t_sel = '0; t_we = 1'b0; t_stb = 1'b0;
    cyc_a = 1'b0; cyc_b = 1'b0;
    last_a = '0; last_b = '0;
    #12;
    chk("rst_ack_a", {31'b0, if_a.wbs_ack_o}, 32'd0);
    chk("rst_err_a", {31'b0, if_a.wbs_err_o}, 32'd0);
    chk("rst_dat_a", if_a.wbs_dat_o, 32'd0);
    chk("rst_ack_b", {31'b0, if_b.wbs_ack_o}, 32'd0);
    chk("rst_dat_b", if_b.wbs_dat_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill both arrays so every model word is defined.
    for (int i = 0; i < 2**AW_A; i++) txn(0, 1, BASE_A + 32'(4*i), $urandom, 4'hF, 0);
    for (int i = 0; i < 2**AW_B; i++) txn(1, 1, BASE_B + 32'(4*i), $urandom, 4'hF, 0);

    // Full-word write/read at zero wait states.
    txn(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
    // Byte lanes; empty sel still acks.
    txn(0, 1, 32'h20, 32'h1122_3344, 4'hF, 0);
    txn(0, 1, 32'h20, 32'h0000_AA00, 4'b0010, 0);
    txn(0, 0, 32'h20, 32'h0, 4'h3, 0);
    txn(0, 1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 0);
    txn(0, 0, 32'h20, 32'h0, 4'h1, 0);

    // Wait-state read, then a write aborted by dropping cyc.
    txn(1, 0, BASE_B + 32'h8, 32'h0, 4'hF, 0);
    a = BASE_B + 32'h14;
    t_addr = a; t_dat = ~mem_b[m_idx(1, a)]; t_sel = 4'hF; t_we = 1'b1; t_stb = 1'b1; cyc_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc_b = 1'b0; t_stb = 1'b0;
    sticky = '0;
    repeat (8) begin
      @(posedge clk); #1;
      sticky = sticky | {30'b0, if_b.wbs_ack_o, if_b.wbs_err_o};
    end
    chk("abort_resp", sticky, 32'd0);
    txn(1, 0, a, 32'h0, 4'hF, 0);

    // Window edges.
    txn(0, 0, BASE_A + 32'(4 * 2**AW_A), 32'h0, 4'hF, 0);
    txn(0, 1, 32'hFFFF_FFFC, 32'h1234_5678, 4'hF, 0);
    txn(1, 0, BASE_B + 32'(4 * 2**AW_B), 32'h0, 4'hF, 0);
    txn(1, 0, BASE_B - 32'd4, 32'h0, 4'hF, 0);
    txn(1, 0, BASE_B + 32'(4 * 2**AW_B) - 32'd4, 32'h0, 4'hF, 0);

    // stb held over alternating write/read requests.
    txn(0, 1, 32'h40, 32'hCAFE_0001, 4'hF, 1);
    txn(0, 0, 32'h40, 32'h0, 4'hF, 1);
    txn(0, 1, 32'h44, 32'hCAFE_0002, 4'hC, 1);
    txn(0, 0, 32'h44, 32'h0, 4'hF, 0);

    // Reset during the wait phase of a write.
    txn(0, 0, 32'h10, 32'h0, 4'hF, 0);
    txn(1, 1, BASE_B + 32'h30, 32'h5A5A_A5A5, 4'hF, 0);
    txn(1, 0, BASE_B + 32'h30, 32'h0, 4'hF, 0);
    a = BASE_B + 32'h30;
    t_addr = a; t_dat = 32'h0BAD_0BAD; t_sel = 4'hF; t_we = 1'b1; t_stb = 1'b1; cyc_b = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ack", {31'b0, if_b.wbs_ack_o}, 32'd0);
    chk("arst_err", {31'b0, if_b.wbs_err_o}, 32'd0);
    chk("arst_dat_b", if_b.wbs_dat_o, 32'd0);
    chk("arst_dat_a", if_a.wbs_dat_o, 32'd0);
    cyc_b = 1'b0; t_stb = 1'b0;
    last_a = '0; last_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ack", {31'b0, if_b.wbs_ack_o}, 32'd0);
    txn(1, 0, a, 32'h0, 4'hF, 0);
    txn(0, 0, 32'h40, 32'h0, 4'hF, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit b;
      b = 1'($urandom_range(0, 1));
      d = $urandom;
      txn(b, 1'($urandom_range(0, 1)), rnd_addr(b), d, 4'($urandom), i % 7 == 3 && 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
